// File: rtl/simon_pkg.sv
// Shared constants and helpers for the simon game and its input conditioning.
// Defaults here are the values any future top-level wiring should start from.
package simon_pkg;

   localparam int unsigned DEBOUNCE_MS_DEFAULT = 10;
   localparam int unsigned SYNC_STAGES_DEFAULT = 2;
   localparam int unsigned PRE_W               = 16;
   localparam int unsigned CNT_W               = 8;

   // Millisecond strobe: >= compare so a lowered period never strands the counter.
   function automatic logic ms_tick_f(input logic [PRE_W-1:0] pre_cnt,
                                      input logic [PRE_W-1:0] ticks_per_milli);
      logic [PRE_W-1:0] last_v;
      last_v = ticks_per_milli - 16'd1;
      return (ticks_per_milli <= 16'd1) || (pre_cnt >= last_v);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: input synchroniser, millisecond stability filter and
// registered press/release pulses that coincide with the committed level change.
module debounce_channel
   import simon_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
   parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic ms_tick,
   input  logic din,
   output logic stable,
   output logic stable_next,
   output logic press,
   output logic rel
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   stable_q;
   logic                   stable_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   press_q;
   logic                   press_d;
   logic                   rel_q;
   logic                   rel_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser shift chain; the oldest stage is the filtered sample.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
   end

   // Any agreement restarts the filter; a mismatch only advances on ms ticks.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      if (s == stable_q) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (ms_tick) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = s;
            cnt_d    = {CNT_W{1'b0}};
            press_d  = s;
            rel_d    = ~s;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= {SYNC_STAGES{1'b0}};
         stable_q <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         press_q  <= 1'b0;
         rel_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
         rel_q    <= rel_d;
      end
   end

   assign stable      = stable_q;
   assign stable_next = stable_d;
   assign press       = press_q;
   assign rel         = rel_q;

endmodule

// File: rtl/btn_debounce.sv
// Button input conditioner for the simon core: shared millisecond prescaler,
// polarity correction and NUM_BTN independent debounce channels.
module btn_debounce
   import simon_pkg::*;
#(
   parameter int unsigned NUM_BTN     = 4,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
   parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        ticks_per_milli,
   input  logic               btn_invert,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic               any_pressed
);

   logic [PRE_W-1:0]   pre_cnt_q;
   logic [PRE_W-1:0]   pre_cnt_d;
   logic               ms_tick;
   logic [NUM_BTN-1:0] pins;
   logic [NUM_BTN-1:0] stable_next;
   logic               any_pressed_q;
   logic               any_pressed_d;

   // Polarity is fixed before the synchroniser so an invert change is filtered too.
   assign pins    = btn_raw ^ {NUM_BTN{btn_invert}};
   assign ms_tick = ms_tick_f(pre_cnt_q, ticks_per_milli);

   // Prescaler next state and the early OR that keeps any_pressed aligned with btn.
   always_comb begin
      pre_cnt_d     = pre_cnt_q + 16'd1;
      any_pressed_d = |stable_next;
      if (ms_tick) begin
         pre_cnt_d = {PRE_W{1'b0}};
      end else begin
         pre_cnt_d = pre_cnt_q + 16'd1;
      end
   end

   // Shared registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_q     <= {PRE_W{1'b0}};
         any_pressed_q <= 1'b0;
      end else begin
         pre_cnt_q     <= pre_cnt_d;
         any_pressed_q <= any_pressed_d;
      end
   end

   assign any_pressed = any_pressed_q;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEBOUNCE_MS (DEBOUNCE_MS)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .ms_tick     (ms_tick),
         .din         (pins[gi]),
         .stable      (btn[gi]),
         .stable_next (stable_next[gi]),
         .press       (btn_press[gi]),
         .rel         (btn_release[gi])
      );
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with ticks_per_milli=4, DEBOUNCE_MS=3, SYNC_STAGES=2.
module tb_btn_debounce;

   logic        clk;
   logic        rst;
   logic [15:0] ticks_per_milli;
   logic        btn_invert;
   logic [3:0]  btn_raw;
   logic [3:0]  btn;
   logic [3:0]  btn_press;
   logic [3:0]  btn_release;
   logic        any_pressed;

   int checks = 0;
   int errors = 0;

   btn_debounce #(
      .NUM_BTN     (4),
      .SYNC_STAGES (2),
      .DEBOUNCE_MS (3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ticks_per_milli (ticks_per_milli),
      .btn_invert      (btn_invert),
      .btn_raw         (btn_raw),
      .btn             (btn),
      .btn_press       (btn_press),
      .btn_release     (btn_release),
      .any_pressed     (any_pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe one channel for ncyc cycles, sampling on the falling edge.
   task automatic watch(input int ch, input int ncyc,
                        output int rise, output int fall,
                        output int np, output int nr, output int first_p, output int first_r);
      logic prev;
      rise = -1; fall = -1; np = 0; nr = 0; first_p = -1; first_r = -1;
      prev = btn[ch];
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         if (btn[ch] && !prev && rise < 0) rise = i;
         if (!btn[ch] && prev && fall < 0) fall = i;
         if (btn_press[ch]) begin
            np++;
            if (first_p < 0) first_p = i;
         end
         if (btn_release[ch]) begin
            nr++;
            if (first_r < 0) first_r = i;
         end
         prev = btn[ch];
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ticks_per_milli = 16'd4; btn_invert = 1'b0; btn_raw = 4'b0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({btn, btn_press, btn_release, any_pressed} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 0", {btn, btn_press, btn_release, any_pressed});
      end
   endtask

   task automatic test_clean_press();
      int rise, fall, np, nr, fp, fr;
      btn_raw[0] = 1'b1;
      watch(0, 60, rise, fall, np, nr, fp, fr);
      checks++;
      if (rise < 11 || rise > 15) begin
         errors++; $display("FAIL press_latency: got %0d required 11..15", rise);
      end
      checks++;
      if (np !== 1) begin
         errors++; $display("FAIL press_count: got %0d required 1", np);
      end
      checks++;
      if (fp !== rise) begin
         errors++; $display("FAIL press_align: pulse at %0d required %0d", fp, rise);
      end
      checks++;
      if (nr !== 0 || any_pressed !== 1'b1) begin
         errors++; $display("FAIL press_side: releases %0d any %b required 0 and 1", nr, any_pressed);
      end
   endtask

   task automatic test_clean_release();
      int rise, fall, np, nr, fp, fr;
      btn_raw[0] = 1'b0;
      watch(0, 40, rise, fall, np, nr, fp, fr);
      checks++;
      if (fall < 11 || fall > 15) begin
         errors++; $display("FAIL release_latency: got %0d required 11..15", fall);
      end
      checks++;
      if (nr !== 1 || fr !== fall) begin
         errors++; $display("FAIL release_pulse: count %0d at %0d required 1 at %0d", nr, fr, fall);
      end
      checks++;
      if (np !== 0 || any_pressed !== 1'b0) begin
         errors++; $display("FAIL release_side: presses %0d any %b required 0 and 0", np, any_pressed);
      end
   endtask

   task automatic test_bounce();
      int rise, fall, np, nr, fp, fr;
      int bp = 0;
      int br = 0;
      for (int i = 0; i < 24; i++) begin
         if (i == 0) btn_raw[1] = 1'b1;
         else if (i % 3 == 0) btn_raw[1] = ~btn_raw[1];
         @(negedge clk);
         if (btn_press[1]) bp++;
         if (btn_release[1]) br++;
      end
      btn_raw[1] = 1'b1;
      watch(1, 40, rise, fall, np, nr, fp, fr);
      checks++;
      if (bp + np !== 1 || bp !== 0) begin
         errors++; $display("FAIL bounce_press_count: during %0d after %0d required 0 and 1", bp, np);
      end
      checks++;
      if (fp < 11 || fp > 15) begin
         errors++; $display("FAIL bounce_latency: got %0d required 11..15", fp);
      end
      checks++;
      if (br + nr !== 0) begin
         errors++; $display("FAIL bounce_release: got %0d required 0", br + nr);
      end
      btn_raw[1] = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (btn !== 4'b0000) begin
         errors++; $display("FAIL bounce_cleanup: btn %b required 0000", btn);
      end
   endtask

   task automatic test_glitch();
      int seen = 0;
      btn_raw[2] = 1'b1;
      for (int i = 0; i < 46; i++) begin
         if (i == 6) btn_raw[2] = 1'b0;
         @(negedge clk);
         if (btn[2] || btn_press[2] || btn_release[2]) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL glitch: %0d active cycles required 0", seen);
      end
   endtask

   task automatic test_simultaneous();
      int found = -1;
      logic prev_any = 1'b0;
      btn_raw = 4'b1001;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (btn_press !== 4'b0000 && found < 0) begin
            found = i;
            checks++;
            if (btn_press !== 4'b1001 || btn !== 4'b1001) begin
               errors++; $display("FAIL simul_press: press %b btn %b required 1001", btn_press, btn);
            end
            checks++;
            if (any_pressed !== 1'b1 || prev_any !== 1'b0) begin
               errors++; $display("FAIL simul_any: now %b before %b required 1 and 0", any_pressed, prev_any);
            end
         end
         prev_any = any_pressed;
      end
      checks++;
      if (found < 11 || found > 15) begin
         errors++; $display("FAIL simul_latency: got %0d required 11..15", found);
      end
      btn_raw = 4'b0000;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_invert_reset();
      int rise, fall, np, nr, fp, fr;
      int seen = 0;
      int r0 = -1;
      int r3 = -1;
      int rel_seen = 0;
      btn_invert = 1'b1; btn_raw = 4'b1111;
      repeat (30) begin
         @(negedge clk);
         if (btn !== 4'b0000 || btn_press !== 4'b0000 || btn_release !== 4'b0000) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL invert_idle: %0d active cycles required 0", seen);
      end
      btn_raw = 4'b0111;
      watch(3, 30, rise, fall, np, nr, fp, fr);
      checks++;
      if (rise < 11 || rise > 15 || np !== 1) begin
         errors++; $display("FAIL invert_press: at %0d count %0d required 11..15 and 1", rise, np);
      end
      btn_raw = 4'b0110;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({btn, btn_press, btn_release, any_pressed} !== 13'd0) begin
         errors++; $display("FAIL midreset_outputs: got %b required 0", {btn, btn_press, btn_release, any_pressed});
      end
      rst = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            checks++;
            if ({btn, btn_press, btn_release, any_pressed} !== 13'd0) begin
               errors++; $display("FAIL postreset_outputs: got %b required 0", {btn, btn_press, btn_release, any_pressed});
            end
         end
         if (btn_press[0] && r0 < 0) r0 = i;
         if (btn_press[3] && r3 < 0) r3 = i;
         if (btn_release !== 4'b0000) rel_seen++;
      end
      checks++;
      if (r0 !== 12 || r3 !== 12) begin
         errors++; $display("FAIL postreset_press: ch0 %0d ch3 %0d required 12", r0, r3);
      end
      checks++;
      if (rel_seen !== 0 || btn !== 4'b1001) begin
         errors++; $display("FAIL postreset_state: releases %0d btn %b required 0 and 1001", rel_seen, btn);
      end
   endtask

   task automatic test_zero_ticks();
      int rise, fall, np, nr, fp, fr;
      ticks_per_milli = 16'd0;
      btn_raw = 4'b1111;
      watch(3, 20, rise, fall, np, nr, fp, fr);
      checks++;
      if (fall < 5 || fall > 6) begin
         errors++; $display("FAIL zero_ticks_latency: got %0d required 5..6", fall);
      end
      checks++;
      if (nr !== 1 || fr !== fall || btn !== 4'b0000 || any_pressed !== 1'b0) begin
         errors++; $display("FAIL zero_ticks_state: releases %0d btn %b any %b required 1 0000 0", nr, btn, any_pressed);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_clean_release();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_invert_reset();
      test_zero_ticks();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Input conditioner between the raw push-button pins and the `simon` game core. It synchronises each button to `clk`, removes contact bounce with a millisecond-based stability filter, and drives the clean `btn` level bus the game FSM consumes. It also provides one-cycle press and release event pulses. The millisecond base comes from the same `ticks_per_milli` input the game core uses, so debounce time tracks the system clock.

## Interface
- `NUM_BTN`, 4: number of button channels.
- `SYNC_STAGES`, 2: flip-flop stages in each input synchroniser (≥2).
- `DEBOUNCE_MS`, 10: milliseconds of continuous stability required to commit a new level (1..255).

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ticks_per_milli`  in  16  clk cycles per millisecond; 0 is treated as 1.
- `btn_invert`  in  1  1 = pins are active-low; applied before the synchroniser.
- `btn_raw`  in  NUM_BTN  asynchronous button pins.
- `btn`  out  NUM_BTN  debounced level, 1 = pressed.
- `btn_press`  out  NUM_BTN  one-cycle pulse on a committed 0→1 transition.
- `btn_release`  out  NUM_BTN  one-cycle pulse on a committed 1→0 transition.
- `any_pressed`  out  1  OR of `btn`, registered.

## Operation
- **Input path:** `btn_raw ^ {NUM_BTN{btn_invert}}` feeds a SYNC_STAGES-deep shift chain per bit. The last stage is `s`.
- **Prescaler:** `pre_cnt` is 16 bits wide.
  - `ms_tick` = (`pre_cnt` ≥ `ticks_per_milli` − 1) or (`ticks_per_milli` ≤ 1).
  - On `ms_tick`, `pre_cnt` ← 0. Otherwise `pre_cnt` increments.
  - Because the compare is ≥, reducing `ticks_per_milli` mid-run never leaves the counter stranded.
- **Per channel:** state is `stable` (1 bit) and `cnt` (8 bits).
  - If `s == stable`: `cnt` ← 0. Any agreement, even for one cycle, restarts the filter.
  - If `s != stable` and `ms_tick`:
    - when `cnt == DEBOUNCE_MS − 1`: `stable` ← `s`, `cnt` ← 0, and the matching press or release pulse is asserted.
    - otherwise `cnt` ← `cnt` + 1.
  - If `s != stable` and no `ms_tick`: hold.
- **Outputs:** `btn` = `stable`, registered. Pulses are registered and coincide with the cycle `btn` changes. `any_pressed` is updated in the same cycle as `btn`.
- **Independence:** channels are fully independent. Simultaneous presses on several channels produce pulses in the same cycle. No priority encoding is done here; one-hot checking stays in the game core.
- **`btn_invert` change:** treated as an input change on every channel and filtered normally.

## Timing
- **Reset values:** synchroniser flops 0, `pre_cnt` 0, `stable` 0, `cnt` 0. All outputs are 0 in the first cycle after `rst` deasserts.
- **Reset mid-debounce:** pending count is lost and `btn` returns to 0. A button held through reset is reported as a press after a full debounce period. No pulse is generated by reset itself.
- **Latency:** raw edge → `s` takes SYNC_STAGES cycles. `s` mismatch → commit happens at the DEBOUNCE_MS-th `ms_tick` seen while mismatched. That is (DEBOUNCE_MS−1)·T to DEBOUNCE_MS·T cycles, where T = max(`ticks_per_milli`, 1), plus 1 register cycle.
- **Pulse width:** `btn_press` / `btn_release` are exactly 1 cycle. A new transition cannot commit on the same channel within fewer than (DEBOUNCE_MS−1)·T cycles.
- **Counter width:** `cnt` never exceeds DEBOUNCE_MS − 1, so 8 bits is sufficient and it never wraps.

## Structure
- **Package `simon_pkg`:** default constants `DEBOUNCE_MS_DEFAULT` = 10 and `SYNC_STAGES_DEFAULT` = 2. Shared with any future top-level wiring.
- **Sub-module `debounce_channel`:** `sync` chain + `stable` / `cnt` + edge pulses, one per button. Instantiated NUM_BTN times via generate.
- **Top of this block:** the shared prescaler, the `btn_invert` XOR and the `any_pressed` OR live in `btn_debounce`.

## Test plan
Unless stated otherwise: `ticks_per_milli` = 4, DEBOUNCE_MS = 3, SYNC_STAGES = 2.
- **Clean press:** `btn_raw[0]` held high for 60 cycles → `btn[0]` rises 11–15 cycles after the raw edge. `btn_press[0]` is high exactly 1 cycle, aligned with the rise.
- **Clean release:** release after the clean press → `btn_release[0]` is a single pulse in the same latency window.
- **Bounce:** `btn_raw[1]` toggles every 3 cycles for 24 cycles, then stays high → exactly one `btn_press[1]`. It comes 11–15 cycles after the final edge, with no release pulses.
- **Glitch rejection:** a 6-cycle high glitch on `btn_raw[2]` → `btn` stays 0 and no pulses.
- **Simultaneous press:** `btn_raw` = 4'b1001 in one cycle → `btn_press` = 4'b1001 in the same cycle, and `any_pressed` rises with it.
- **Invert and reset:** `btn_invert` = 1 with pins idle high → `btn` = 0.
  - Pull `btn_raw[3]` low → press reported.
  - Assert `rst` for 2 cycles mid-debounce → all outputs 0.
  - Button still held after reset → `btn_press[3]` again after a full debounce period.
  - `ticks_per_milli` = 0 → commit after 3–4 cycles + sync latency.
